mem_port_arbiter: RTL

- Shares one single-port, fixed-latency memory between instruction fetch (read-only) and the memory stage (read/write).
- Sits between the fetch/memory stages and a unified memory macro.
- Sequences each access through an issue/wait/response FSM with a valid/ack handshake per requester.
- Drives stall lines back to the pipeline; data accesses take priority, and a defer counter prevents fetch starvation.

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/mem_arb_lat_timer.sv | 29 ++
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
// The optional perf counters in mem_port_arbiter are enabled with MEM_ARB_PERF_EN.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  localparam int MEM_LAT_DEF   = 1;
  localparam int MAX_DEFER_DEF = 3;
endpackage

// File: rtl/mem_arb_lat_timer.sv
// Load/decrement counter that flags the final cycle of the memory latency window.
module mem_arb_lat_timer #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic last
);
  localparam int CNT_W = $clog2(LAT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = CNT_W'(LAT);
    else if (dec && cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data-stage accesses onto one fixed-latency memory port.
// Define MEM_ARB_PERF_EN to add saturating stall-cycle counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int W         = 16,
  parameter int ADDR_W    = 16,
  parameter int MEM_LAT   = MEM_LAT_DEF,
  parameter int MAX_DEFER = MAX_DEFER_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [W-1:0]      if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [W-1:0]      d_wdata,
  output logic              d_ack,
  output logic [W-1:0]      d_rdata,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [W-1:0]      mem_wdata,
  input  logic [W-1:0]      mem_rdata,
`ifdef MEM_ARB_PERF_EN
  output logic [15:0]       perf_if_stall_cnt,
  output logic [15:0]       perf_d_stall_cnt,
`endif
  output logic              busy
);
  localparam int DEFER_W = $clog2(MAX_DEFER + 1);

  arb_state_e        state_q, state_d;
  logic              gnt_q, gnt_d, gnt_sel;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [W-1:0]      mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d, d_ack_q, d_ack_d;
  logic [W-1:0]      if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic [DEFER_W-1:0] defer_q, defer_d;
  logic              defer_max, lat_load, lat_dec, lat_last;

  assign lat_load = (state_q == ISSUE);
  assign lat_dec  = (state_q == WAIT);

  mem_arb_lat_timer #(.LAT(MEM_LAT)) u_lat (
    .clk  (clk),
    .rst  (rst),
    .load (lat_load),
    .dec  (lat_dec),
    .last (lat_last)
  );

  // Data wins a tie unless fetch has already been passed over MAX_DEFER times.
  assign defer_max = (defer_q == DEFER_W'(MAX_DEFER));
  assign gnt_sel   = (d_req && !(if_req && defer_max)) ? GNT_D : GNT_IF;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (if_req || d_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (lat_last) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = gnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    defer_d     = defer_q;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          gnt_d    = gnt_sel;
          mem_en_d = 1'b1;
          if (gnt_sel == GNT_D) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            if (if_req && !defer_max) defer_d = defer_q + DEFER_W'(1);
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            defer_d     = '0;
          end
        end
      end
      WAIT: begin
        if (lat_last) begin
          if (gnt_q == GNT_IF) begin
            if_rdata_d = mem_rdata;
            if_ack_d   = 1'b1;
          end else begin
            d_ack_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q       <= GNT_IF;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      defer_q     <= '0;
    end else begin
      gnt_q       <= gnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      defer_q     <= defer_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);
  assign if_stall  = if_req & ~if_ack_q;
  assign d_stall   = d_req & ~d_ack_q;

`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_if_q, perf_d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_q <= '0;
      perf_d_q  <= '0;
    end else begin
      if (if_stall && perf_if_q != 16'hFFFF) perf_if_q <= perf_if_q + 16'd1;
      if (d_stall && perf_d_q != 16'hFFFF)   perf_d_q  <= perf_d_q + 16'd1;
    end
  end

  assign perf_if_stall_cnt = perf_if_q;
  assign perf_d_stall_cnt  = perf_d_q;
`endif
endmodule
